// File: rtl/stack_drain_if.sv
// rtl/stack_drain_if.sv - stack pop port and drained-word stream shared by stack_drain and its neighbours
interface stack_drain_if #(
    parameter int WIDTH = 8
);
    logic             stk_pop;
    logic [WIDTH-1:0] stk_data;
    logic             stk_error;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    modport master (
        output stk_pop,
        input  stk_data,
        input  stk_error,
        output out_data,
        output out_valid,
        input  out_ready
    );

    modport slave (
        input  stk_pop,
        output stk_data,
        output stk_error,
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/stack_drain.sv
// rtl/stack_drain.sv - LIFO readout controller; STACK_DRAIN_TIMEOUT_EN adds a sink-wait timeout (timed_out port)
module stack_drain #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 5
`ifdef STACK_DRAIN_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 abort,
    stack_drain_if.master        bus,
    output logic                 busy,
    output logic                 done,
    output logic [CNT_WIDTH-1:0] count,
`ifdef STACK_DRAIN_TIMEOUT_EN
    output logic                 timed_out,
`endif
    output logic                 aborted
);

    typedef enum logic [2:0] {
        IDLE,
        POP,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t               state, state_n;
    logic                 stk_pop_q, stk_pop_n;
    logic [WIDTH-1:0]     out_data_q, out_data_n;
    logic                 out_valid_q, out_valid_n;
    logic                 busy_q, busy_n;
    logic                 done_q, done_n;
    logic [CNT_WIDTH-1:0] count_q, count_n;
    logic [CNT_WIDTH-1:0] count_inc;
    logic                 aborted_q, aborted_n;

`ifdef STACK_DRAIN_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TO_W-1:0] wait_q, wait_n;
    logic            timed_out_q, timed_out_n;
`endif

    assign count_inc = count_q + CNT_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            stk_pop_q   <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            count_q     <= '0;
            aborted_q   <= 1'b0;
`ifdef STACK_DRAIN_TIMEOUT_EN
            wait_q      <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state       <= state_n;
            stk_pop_q   <= stk_pop_n;
            out_data_q  <= out_data_n;
            out_valid_q <= out_valid_n;
            busy_q      <= busy_n;
            done_q      <= done_n;
            count_q     <= count_n;
            aborted_q   <= aborted_n;
`ifdef STACK_DRAIN_TIMEOUT_EN
            wait_q      <= wait_n;
            timed_out_q <= timed_out_n;
`endif
        end
    end

    always_comb begin
        state_n     = state;
        out_data_n  = out_data_q;
        out_valid_n = out_valid_q;
        count_n     = count_q;
        aborted_n   = aborted_q;
`ifdef STACK_DRAIN_TIMEOUT_EN
        wait_n      = '0;
        timed_out_n = timed_out_q;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    state_n   = POP;
                    count_n   = '0;
                    aborted_n = 1'b0;
`ifdef STACK_DRAIN_TIMEOUT_EN
                    timed_out_n = 1'b0;
`endif
                end
            end
            POP: begin
                if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end else begin
                    state_n = CAPTURE;
                end
            end
            CAPTURE: begin
                if (abort) begin
                    state_n   = DONE;
                    aborted_n = 1'b1;
                end else if (bus.stk_error) begin
                    state_n = DONE;
                end else begin
                    out_data_n  = bus.stk_data;
                    out_valid_n = 1'b1;
                    state_n     = SEND;
                end
            end
            SEND: begin
                // a handshake coinciding with abort still counts the word
                if (bus.out_ready) begin
                    count_n     = count_inc;
                    out_valid_n = 1'b0;
                end
                if (abort) begin
                    state_n     = DONE;
                    aborted_n   = 1'b1;
                    out_valid_n = 1'b0;
                end else if (bus.out_ready) begin
                    state_n = (count_inc == CNT_MAX) ? DONE : POP;
                end
`ifdef STACK_DRAIN_TIMEOUT_EN
                else if (wait_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    state_n     = DONE;
                    aborted_n   = 1'b1;
                    timed_out_n = 1'b1;
                    out_valid_n = 1'b0;
                end else begin
                    wait_n = wait_q + TO_W'(1);
                end
`endif
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n     = IDLE;
                out_valid_n = 1'b0;
            end
        endcase

        // strobes are registered from the next state so they align with it
        stk_pop_n = (state_n == POP);
        busy_n    = (state_n != IDLE);
        done_n    = (state_n == DONE);
    end

    assign bus.stk_pop   = stk_pop_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign count         = count_q;
    assign aborted       = aborted_q;
`ifdef STACK_DRAIN_TIMEOUT_EN
    assign timed_out     = timed_out_q;
`endif

endmodule

// File: tb/tb_stack_drain.sv
// tb/tb_stack_drain.sv - directed bench for stack_drain with a behavioural LIFO on the pop port
module tb_stack_drain;
    localparam int WIDTH     = 8;
    localparam int CNT_WIDTH = 5;
`ifdef STACK_DRAIN_TIMEOUT_EN
    localparam int TO_CYC = 4;
    localparam int WAIT_C = 3;
`else
    localparam int WAIT_C = 10;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic busy, done, aborted;
    logic [CNT_WIDTH-1:0] count;
`ifdef STACK_DRAIN_TIMEOUT_EN
    logic timed_out;
`endif

    stack_drain_if #(.WIDTH(WIDTH)) bus ();

    stack_drain #(
        .WIDTH(WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
`ifdef STACK_DRAIN_TIMEOUT_EN
        ,
        .TIMEOUT_CYCLES(TO_CYC)
`endif
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .abort(abort),
        .bus(bus),
        .busy(busy),
        .done(done),
        .count(count),
`ifdef STACK_DRAIN_TIMEOUT_EN
        .timed_out(timed_out),
`endif
        .aborted(aborted)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [WIDTH-1:0] mem [0:63];
    int               sp = 0;
    int               pops = 0;
    logic [WIDTH-1:0] rx [$];
    bit               valid_seen = 0;
    bit               prev_wait = 0;
    logic [WIDTH-1:0] prev_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // LIFO model: popped word (or error on empty) appears the cycle after stk_pop
    always @(posedge clk) begin
        if (!reset) begin
            bus.stk_error <= 1'b0;
            bus.stk_data  <= '0;
        end else if (bus.stk_pop) begin
            if (sp == 0) begin
                bus.stk_error <= 1'b1;
            end else begin
                bus.stk_data  <= mem[sp-1];
                bus.stk_error <= 1'b0;
                sp <= sp - 1;
            end
        end else begin
            bus.stk_error <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (bus.stk_pop) pops++;
        if (bus.out_valid) valid_seen = 1;
        if (prev_wait && bus.out_valid) chk("data_stable", bus.out_data, prev_data);
        if (bus.out_valid && bus.out_ready) rx.push_back(bus.out_data);
        prev_wait = bus.out_valid && !bus.out_ready && reset;
        prev_data = bus.out_data;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [WIDTH-1:0] v);
        mem[sp] = v;
        sp = sp + 1;
    endtask

    task automatic clear_mon();
        rx.delete();
        pops = 0;
        valid_seen = 0;
    endtask

    task automatic wait_done(input int max, output bit ok);
        ok = 0;
        for (int i = 0; i < max; i++) begin
            tick();
            if (done) begin
                ok = 1;
                break;
            end
        end
    endtask

    initial begin
        bit ok;
        bus.out_ready = 1'b0;

        reset = 1'b0;
        tick();
        tick();
        chk("rst_stk_pop", bus.stk_pop, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_count", count, 0);
        chk("rst_aborted", aborted, 0);
        reset = 1'b1;
        tick();

        // three words, sink always ready
        sp = 0;
        push(8'h11); push(8'h22); push(8'h33);
        clear_mon();
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("a_busy", busy, 1);
        chk("a_pop", bus.stk_pop, 1);
        tick();
        tick();
        chk("a_latency_valid", bus.out_valid, 1);
        chk("a_first_data", bus.out_data, 8'h33);
        wait_done(40, ok);
        chk("a_done_seen", ok, 1);
        chk("a_count", count, 3);
        chk("a_aborted", aborted, 0);
        chk("a_rx_size", rx.size(), 3);
        chk("a_rx0", rx[0], 8'h33);
        chk("a_rx1", rx[1], 8'h22);
        chk("a_rx2", rx[2], 8'h11);
        chk("a_pops", pops, 4);
        tick();
        chk("a_idle", busy, 0);

        // empty stack
        sp = 0;
        clear_mon();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b_pop", bus.stk_pop, 1);
        tick();
        chk("b_no_done_yet", done, 0);
        tick();
        chk("b_done", done, 1);
        chk("b_count", count, 0);
        chk("b_pops", pops, 1);
        chk("b_no_valid", valid_seen, 0);
        tick();
        chk("b_idle", busy, 0);

        // single word, sink stalls
        sp = 0;
        push(8'hA5);
        clear_mon();
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        for (int i = 0; i < WAIT_C; i++) begin
            chk("c_valid_hold", bus.out_valid, 1);
            chk("c_data_hold", bus.out_data, 8'hA5);
            tick();
        end
        chk("c_single_pop", pops, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("c_valid_drop", bus.out_valid, 0);
        chk("c_count", count, 1);
        wait_done(10, ok);
        chk("c_done_seen", ok, 1);
        chk("c_rx_size", rx.size(), 1);
        chk("c_pops", pops, 2);
        tick();

        // count saturation ends the drain at 31 words
        sp = 0;
        for (int i = 1; i <= 40; i++) push(WIDTH'(i));
        clear_mon();
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done(200, ok);
        chk("d_done_seen", ok, 1);
        chk("d_count", count, 31);
        chk("d_remaining", sp, 9);
        chk("d_rx_size", rx.size(), 31);
        chk("d_rx_first", rx[0], 8'd40);
        chk("d_rx_last", rx[30], 8'd10);
        chk("d_aborted", aborted, 0);
        chk("d_pops", pops, 31);
        tick();

        // abort while stalled in SEND; start during busy ignored
        sp = 0;
        push(8'h01); push(8'h02); push(8'h03);
        clear_mon();
        bus.out_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e_busy", busy, 1);
        chk("e_valid", bus.out_valid, 1);
        chk("e_data", bus.out_data, 8'h03);
        chk("e_pops", pops, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("e_valid_drop", bus.out_valid, 0);
        chk("e_done", done, 1);
        chk("e_aborted", aborted, 1);
        chk("e_count", count, 0);
        tick();
        chk("e_idle", busy, 0);
        chk("e_sp", sp, 2);

        // abort coinciding with handshake
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("e2_aborted_clr", aborted, 0);
        tick();
        tick();
        chk("e2_data", bus.out_data, 8'h02);
        bus.out_ready = 1'b1;
        abort = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        abort = 1'b0;
        chk("e2_done", done, 1);
        chk("e2_count", count, 1);
        chk("e2_aborted", aborted, 1);
        chk("e2_valid", bus.out_valid, 0);
        chk("e2_rx_size", rx.size(), 1);
        tick();

        // abort in IDLE has no effect
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("f_idle_busy", busy, 0);
        chk("f_idle_aborted", aborted, 1);

        // reset mid-drain
        sp = 0;
        push(8'h05); push(8'h06); push(8'h07);
        bus.out_ready = 1'b1;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        chk("g_valid", bus.out_valid, 1);
        chk("g_count", count, 1);
        chk("g_data", bus.out_data, 8'h06);
        reset = 1'b0;
        tick();
        chk("g_rst_valid", bus.out_valid, 0);
        chk("g_rst_data", bus.out_data, 0);
        chk("g_rst_busy", busy, 0);
        chk("g_rst_count", count, 0);
        chk("g_rst_pop", bus.stk_pop, 0);
        chk("g_rst_done", done, 0);
        reset = 1'b1;
        bus.out_ready = 1'b0;
        tick();

`ifdef STACK_DRAIN_TIMEOUT_EN
        sp = 0;
        push(8'h5A);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("t_valid", bus.out_valid, 1);
        chk("t_to_clear", timed_out, 0);
        tick();
        tick();
        tick();
        chk("t_still_wait", bus.out_valid, 1);
        chk("t_no_done", done, 0);
        tick();
        chk("t_done", done, 1);
        chk("t_timed_out", timed_out, 1);
        chk("t_aborted", aborted, 1);
        chk("t_valid_drop", bus.out_valid, 0);
        tick();
        chk("t_idle", busy, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t_to_cleared", timed_out, 0);
        wait_done(10, ok);
        chk("t2_done_seen", ok, 1);
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
